count_capture: RTL

COUNT_CAPTURE -- requirements
Module: count_capture

---
 rtl/count_capture.sv | 80 ++++++++
 1 files changed

// File: rtl/count_capture.sv
// Captures the upstream counter on rising edges of evt into a 4-entry FIFO with sticky overflow.
// Optional COUNT_CAPTURE_SYNC_EN adds a 2-flop synchronizer ahead of edge detection.
module count_capture (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] count,
    input  logic       evt,       // 'event' is a reserved word, so the capture request is named evt
    input  logic       clear,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic [2:0] level,
    output logic       overflow
);
    localparam int DEPTH = 4;

    logic [DEPTH-1:0][7:0] mem;
    logic [1:0]            wptr, rptr;
    logic [2:0]            lvl;
    logic                  ovf;
    logic                  ev_prev;
    logic                  det_in;
    logic                  capture, full, empty, pop, push;

`ifdef COUNT_CAPTURE_SYNC_EN
    logic [1:0] sync_pipe;

    // Synchronizer presets high so an event held across reset release is not seen as an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_pipe <= '1;
        else        sync_pipe <= {sync_pipe[0], evt};
    end
    assign det_in = sync_pipe[1];
`else
    assign det_in = evt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ev_prev <= 1'b1;
        else        ev_prev <= det_in;
    end

    assign capture = det_in & ~ev_prev;
    assign full    = (lvl == 3'(DEPTH));
    assign empty   = (lvl == 3'd0);
    assign pop     = ~empty & rd_ready;
    // A pop frees the slot at the same edge, so a full FIFO can still accept.
    assign push    = capture & (~full | pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
            ovf  <= 1'b0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= count;
                wptr      <= wptr + 2'd1;
            end
            if (pop)
                rptr <= rptr + 2'd1;
            if (capture && full && !pop)
                ovf <= 1'b1;
            if (push && !pop)      lvl <= lvl + 3'd1;
            else if (pop && !push) lvl <= lvl - 3'd1;
        end
    end

    assign rd_valid = ~empty;
    assign rd_data  = empty ? 8'h00 : mem[rptr];
    assign level    = lvl;
    assign overflow = ovf;
endmodule
